// File: rtl/gfx_frag_expand.sv
// gfx_frag_expand: expands tile coverage packets into per-pixel fragments; optional GFX_FRAG_COUNT_EN adds frag_count
module gfx_frag_expand #(
  parameter int TILE_W = 8,
  parameter int TILE_H = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cov_tdata,
  input  logic        cov_tlast,
  input  logic        cov_tvalid,
  output logic        cov_tready,
  output logic [31:0] frag_tdata,
  output logic        frag_tlast,
  output logic        frag_tvalid,
  input  logic        frag_tready,
  output logic        err_malformed
`ifdef GFX_FRAG_COUNT_EN
  ,output logic [31:0] frag_count
`endif
);
  localparam logic [1:0] HDR = 2'd0, MASK = 2'd1, EMIT = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [15:0] ox, oy, dx, dy;
  logic [31:0] mask, src;
  logic [4:0] idx;
  logic cov_hs, frag_hs, only;
  assign cov_tready = !rst && state != EMIT;
  assign cov_hs = cov_tvalid && cov_tready;
  assign frag_hs = frag_tvalid && frag_tready;
  assign src = state == MASK ? cov_tdata : mask & (mask - 32'd1);
  assign only = (src & (src - 32'd1)) == 32'd0;
  // lowest set bit of the mask that supplies the next fragment
  always_comb begin
    idx = 5'd0;
    for (int k = 31; k >= 0; k--) idx = src[k] ? 5'(k) : idx;
  end
  // pixel offset of that bit within the tile
  always_comb begin
    dx = 16'(idx % TILE_W);
    dy = 16'((idx / TILE_W) % TILE_H);
  end
  // packet parser, mask walker and registered fragment output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
      ox <= '0;
      oy <= '0;
      mask <= '0;
      frag_tdata <= '0;
      frag_tlast <= 1'b0;
      frag_tvalid <= 1'b0;
      err_malformed <= 1'b0;
    end else begin
      err_malformed <= 1'b0;
      case (state)
        HDR: if (cov_hs) begin
          ox <= cov_tdata[15:0];
          oy <= cov_tdata[31:16];
          if (cov_tlast) err_malformed <= 1'b1;
          else state <= MASK;
        end
        MASK: if (cov_hs) begin
          mask <= cov_tdata;
          if (!cov_tlast) state <= DRAIN;
          else if (cov_tdata == 32'd0) state <= HDR;
          else begin
            state <= EMIT;
            frag_tvalid <= 1'b1;
            frag_tdata <= {oy + dy, ox + dx};
            frag_tlast <= only;
          end
        end
        DRAIN: if (cov_hs && cov_tlast) begin
          err_malformed <= 1'b1;
          state <= HDR;
        end
        EMIT: if (frag_hs) begin
          mask <= src;
          if (src == 32'd0) begin
            frag_tvalid <= 1'b0;
            state <= HDR;
          end else begin
            frag_tdata <= {oy + dy, ox + dx};
            frag_tlast <= only;
          end
        end
      endcase
    end
  end
`ifdef GFX_FRAG_COUNT_EN
  // running total of accepted fragments, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frag_count <= '0;
    else if (frag_hs) frag_count <= frag_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_gfx_frag_expand.sv
// tb_gfx_frag_expand: table-driven check of gfx_frag_expand plus malformed, backpressure and reset sequences
module tb_gfx_frag_expand;
  logic clk, rst;
  logic [31:0] cov_tdata, frag_tdata;
  logic cov_tlast, cov_tvalid, cov_tready, frag_tlast, frag_tvalid, frag_tready, err_malformed;
`ifdef GFX_FRAG_COUNT_EN
  logic [31:0] frag_count;
`endif
  int n_vec = 0, n_err = 0, err_cnt = 0, tot = 0;
  logic [32:0] q[$];
  logic stl = 1'b0, stl_tl;
  logic [31:0] stl_d;

  typedef struct {
    logic [31:0] hdr, mask;
    int n;
    logic [31:0] f0, f1, fl;
    logic rdy;
  } vec_t;
  vec_t tv[6];

  gfx_frag_expand dut (
    .clk(clk), .rst(rst),
    .cov_tdata(cov_tdata), .cov_tlast(cov_tlast), .cov_tvalid(cov_tvalid), .cov_tready(cov_tready),
    .frag_tdata(frag_tdata), .frag_tlast(frag_tlast), .frag_tvalid(frag_tvalid), .frag_tready(frag_tready),
    .err_malformed(err_malformed)
`ifdef GFX_FRAG_COUNT_EN
    ,.frag_count(frag_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // negedge monitor: records fragment handshakes, error pulses and stall stability
  always @(negedge clk) begin
    if (rst) stl = 1'b0;
    else begin
      if (stl) chk("stall_hold", {frag_tvalid, frag_tlast, frag_tdata}, {1'b1, stl_tl, stl_d});
      if (frag_tvalid && frag_tready) begin
        q.push_back({frag_tlast, frag_tdata});
        tot++;
      end
      if (err_malformed) err_cnt++;
      stl = frag_tvalid && !frag_tready;
      stl_d = frag_tdata;
      stl_tl = frag_tlast;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    logic ok, done;
    done = 1'b0;
    cov_tdata = d;
    cov_tlast = l;
    cov_tvalid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      ok = cov_tready;
      @(posedge clk);
      #1;
      done = ok;
    end
    cov_tvalid = 1'b0;
    if (!done) chk("cov_accept_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_frags(input int n);
    for (int t = 0; t < 200 && q.size() < n; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{32'h0010_0020, 32'h0000_0001, 1, 32'h0010_0020, 32'h0, 32'h0010_0020, 1'b0};
    tv[1] = '{32'h0000_0000, 32'h8000_0101, 3, 32'h0000_0000, 32'h0001_0000, 32'h0003_0007, 1'b0};
    tv[2] = '{32'hFFFF_FFFE, 32'h0000_0400, 1, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0};
    tv[3] = '{32'h0005_0003, 32'h0000_0000, 0, 32'h0, 32'h0, 32'h0, 1'b1};
    tv[4] = '{32'h0100_0200, 32'h0000_0006, 2, 32'h0100_0201, 32'h0100_0202, 32'h0100_0202, 1'b0};
    tv[5] = '{32'h0002_0001, 32'h0000_8000, 1, 32'h0003_0008, 32'h0, 32'h0003_0008, 1'b0};
    rst = 1'b1;
    cov_tdata = '0;
    cov_tlast = 1'b0;
    cov_tvalid = 1'b0;
    frag_tready = 1'b1;
    #2;
    chk("reset_ready", {63'd0, cov_tready}, 64'd0);
    chk("reset_outs", {frag_tvalid, frag_tlast, err_malformed, frag_tdata}, 64'd0);
`ifdef GFX_FRAG_COUNT_EN
    chk("reset_count", {32'd0, frag_count}, 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {63'd0, cov_tready}, 64'd1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      int e0;
      e0 = err_cnt;
      q.delete();
      send_word(tv[v].hdr, 1'b0);
      send_word(tv[v].mask, 1'b1);
      chk($sformatf("v%0d_ready_after_mask", v), {63'd0, cov_tready}, {63'd0, tv[v].rdy});
      chk($sformatf("v%0d_first_valid", v), {63'd0, frag_tvalid}, {63'd0, tv[v].n > 0});
      wait_frags(tv[v].n);
      chk($sformatf("v%0d_count", v), 64'(q.size()), 64'(tv[v].n));
      if (tv[v].n > 0 && q.size() > 0) chk($sformatf("v%0d_first", v), {32'd0, q[0][31:0]}, {32'd0, tv[v].f0});
      if (tv[v].n > 1 && q.size() > 1) chk($sformatf("v%0d_second", v), {32'd0, q[1][31:0]}, {32'd0, tv[v].f1});
      if (tv[v].n > 0 && q.size() > 0) chk($sformatf("v%0d_last", v), {32'd0, q[q.size()-1][31:0]}, {32'd0, tv[v].fl});
      for (int k = 0; k < q.size(); k++) chk($sformatf("v%0d_tlast%0d", v, k), {63'd0, q[k][32]}, {63'd0, k == tv[v].n - 1});
      chk($sformatf("v%0d_no_err", v), 64'(err_cnt - e0), 64'd0);
    end

    begin : malformed
      int e0;
      e0 = err_cnt;
      q.delete();
      send_word(32'h1111_2222, 1'b1);
      chk("hdr_tlast_err_pulse", {63'd0, err_malformed}, 64'd1);
      send_word(32'h0003_0004, 1'b0);
      send_word(32'h0000_00FF, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b1);
      chk("drain_err_pulse", {63'd0, err_malformed}, 64'd1);
      send_word(32'h0007_0009, 1'b0);
      send_word(32'h0000_0003, 1'b1);
      wait_frags(2);
      chk("malformed_err_count", 64'(err_cnt - e0), 64'd2);
      chk("recover_count", 64'(q.size()), 64'd2);
      if (q.size() == 2) begin
        chk("recover_f0", {31'd0, q[0]}, {31'd0, 1'b0, 32'h0007_0009});
        chk("recover_f1", {31'd0, q[1]}, {31'd0, 1'b1, 32'h0007_000A});
      end
    end

    begin : backpressure
      int t0, m;
      logic seen;
      t0 = tot;
      q.delete();
      seen = 1'b0;
      send_word(32'h0020_0030, 1'b0);
      frag_tready = 1'b0;
      send_word(32'hFFFF_FFFF, 1'b1);
      for (int t = 0; t < 400 && !seen; t++) begin
        frag_tready = 1'($urandom_range(0, 1));
        if (frag_tvalid && frag_tready && frag_tlast) seen = 1'b1;
        @(posedge clk);
        #1;
      end
      chk("bp_finished", {63'd0, seen}, 64'd1);
      chk("bp_next_hdr_ready", {62'd0, cov_tready, frag_tvalid}, 64'd2);
      frag_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_count", 64'(q.size()), 64'd32);
      m = 0;
      for (int k = 0; k < q.size(); k++)
        if (q[k] !== {k == 31, 16'h0020 + 16'(k / 8), 16'h0030 + 16'(k % 8)}) m++;
      chk("bp_data_order", 64'(m), 64'd0);
`ifdef GFX_FRAG_COUNT_EN
      chk("bp_frag_count", {32'd0, frag_count - 32'(t0)}, 64'd32);
`endif
    end

    begin : mid_reset
      q.delete();
      frag_tready = 1'b0;
      send_word(32'h0000_0000, 1'b0);
      send_word(32'h0000_00FF, 1'b1);
      @(posedge clk);
      #1;
      chk("pre_reset_valid", {63'd0, frag_tvalid}, 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_reset_outs", {frag_tvalid, frag_tlast, frag_tdata, cov_tready}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      frag_tready = 1'b1;
      #1;
`ifdef GFX_FRAG_COUNT_EN
      chk("post_reset_count", {32'd0, frag_count}, 64'd0);
`endif
      chk("post_reset_ready", {63'd0, cov_tready}, 64'd1);
      send_word(32'h0001_0001, 1'b0);
      send_word(32'h0000_0100, 1'b1);
      wait_frags(1);
      chk("post_reset_frags", 64'(q.size()), 64'd1);
      if (q.size() > 0) chk("post_reset_f0", {31'd0, q[0]}, {31'd0, 1'b1, 32'h0002_0001});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gfx_frag_expand.md
# gfx_frag_expand

Fragment expander directly downstream of `gfx_raster`. It consumes the coverage packet stream, where each packet is a tile-origin header followed by a 32-bit coverage mask. For every set mask bit it emits one fragment word carrying absolute pixel coordinates, at a rate of one fragment per cycle, for the shader/ROP stages.

## Interface
Parameters:
- `TILE_W`, default 8: tile width in pixels; `TILE_W*TILE_H` must equal 32.
- `TILE_H`, default 4: tile height in pixels.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cov_tdata`  in  32  coverage stream data.
- `cov_tlast`  in  1  last word of coverage packet.
- `cov_tvalid`  in  1  coverage word valid.
- `cov_tready`  out  1  block accepts coverage word.
- `frag_tdata`  out  32  fragment `{y[15:0], x[15:0]}`.
- `frag_tlast`  out  1  last fragment of the current tile.
- `frag_tvalid`  out  1  fragment valid.
- `frag_tready`  in  1  downstream accepts fragment.
- `err_malformed`  out  1  one-cycle pulse on a malformed packet.
- `frag_count`  out  32  fragments emitted; present only with `GFX_FRAG_COUNT_EN`.

## Operation
- Packet format: word 0 is the header `{oy[15:0], ox[15:0]}`, the tile origin. Word 1 is the mask. Bit `i` covers pixel `(ox + i % TILE_W, oy + i / TILE_W)`. Well-formed packet: exactly 2 words, with `tlast` on word 1.
- FSM states: HDR, MASK, EMIT, DRAIN.
- HDR:
  - `cov_tready=1`. On a handshake, latch the origin.
  - If `tlast=1`: pulse `err_malformed` and stay in HDR.
  - Otherwise go to MASK.
- MASK:
  - `cov_tready=1`. On a handshake, latch the mask.
  - If `tlast=0`: go to DRAIN.
  - Else, if mask==0: go to HDR with no fragments (not an error).
  - Else: go to EMIT.
- DRAIN:
  - `cov_tready=1`. Discard words until a `tlast` handshake.
  - On that handshake, pulse `err_malformed` and go to HDR. The latched mask is dropped (no fragments).
- EMIT:
  - `cov_tready=0`.
  - The lowest set bit `i` of the remaining mask is the current fragment.
  - `frag_tlast=1` iff `i` is the only remaining set bit.
  - On a `frag_tvalid & frag_tready` handshake, clear bit `i`. If it was the last bit, go to HDR.
- Coordinate arithmetic: 16-bit unsigned, wraps modulo 2^16 (origin `16'hFFFE` + 3 → `16'h0001`). No saturation.
- Fragments are emitted in ascending bit order.

## Timing
- Output register: `frag_*` are driven from flops.
  - The first fragment is valid the cycle after the mask handshake.
  - The outputs change only after a handshake, or when they load on entry to EMIT.
- Throughput:
  - 1 fragment/cycle while `frag_tready=1`.
  - A packet of N set bits occupies 2 input cycles + N output cycles.
  - There is no overlap: the next header is accepted the cycle after the last fragment handshake.
- Stall: with `frag_tvalid=1` and `frag_tready=0`, `frag_tdata` and `frag_tlast` hold stable, and `frag_tvalid` does not drop.
- `err_malformed` asserts in the cycle after the offending handshake, for exactly one cycle.
- Reset values: state HDR, `cov_tready=0` during reset then 1, `frag_tvalid=0`, `frag_tlast=0`, `frag_tdata=0`, `err_malformed=0`, `frag_count=0`.
- Reset mid-EMIT abandons the remaining fragments. No partial output follows reset.

## Configuration
- `GFX_FRAG_COUNT_EN`:
  - Defined: `frag_count` exists. It increments on every fragment handshake and wraps at 2^32.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Header `32'h0010_0020`, mask `32'h0000_0001` with `tlast` → exactly one fragment `32'h0010_0020`, `frag_tlast=1`.
- Origin (0,0), mask `32'h8000_0101` → fragments (0,0), (0,1), (7,3) in that order. `tlast` only on (7,3).
- Mask `0` → no fragments, no error, and the next header is accepted on the following cycle.
- Header with `tlast=1`, then a 3-word packet → two `err_malformed` pulses, no fragments, and a subsequent good packet expands correctly.
- Mask `32'hFFFF_FFFF` with random `frag_tready` backpressure:
  - Exactly 32 fragments, with data stable across stalls.
  - With `GFX_FRAG_COUNT_EN`, `frag_count=32`.
- Origin `32'hFFFF_FFFE`, mask bit 10 → fragment `{16'h0000, 16'h0000}` (x=FFFE+2, y=FFFF+1, both wrapped).
- Assert `rst` mid-EMIT → `frag_tvalid=0` immediately, then clean expansion of the next packet.
